ws2812_rx: RTL and testbench

- Receiver for the WS2812 single-wire NZR LED protocol. It is the other end of the link driven by the ws2812 transmitter.
- Samples the serial line, classifies each bit by high-pulse width and assembles 24-bit pixels. Reports each pixel with its index in the frame, and detects the reset/latch gap.
- Used in loopback self-test, for checking the transmitter in hardware, and as the front end of a daisy-chain pixel emulator.

---
 rtl/ws2812_rx.sv | 178 +++++++++++++++++
 tb/tb_ws2812_rx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NZR line receiver.
// Synchronizes the serial line, classifies each high pulse by its width,
// assembles 24-bit GRB pixels and reports them as {R,G,B} with their frame
// index. The latch gap ends a frame. Define WS2812_RX_FORWARD_EN to add the
// daisy-chain forwarding output dout.
module ws2812_rx #(
    parameter int NUM_LEDS     = 144,
    parameter int CLK_MHZ      = 16,
    parameter int T_BIT_THRESH = (CLK_MHZ * 550) / 1000,
    parameter int T_MIN_HIGH   = (CLK_MHZ * 150) / 1000,
    parameter int T_MAX_HIGH   = CLK_MHZ * 2,
    parameter int T_RESET      = CLK_MHZ * 50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic        error,
    output logic        overflow
`ifdef WS2812_RX_FORWARD_EN
    ,
    output logic        dout
`endif
);

    localparam logic [11:0] C_THRESH = 12'(T_BIT_THRESH);
    localparam logic [11:0] C_MIN    = 12'(T_MIN_HIGH);
    localparam logic [11:0] C_MAX    = 12'(T_MAX_HIGH);
    localparam logic [11:0] C_RESET  = 12'(T_RESET);

    typedef enum logic [1:0] {
        S_SYNC,
        S_LOW,
        S_HIGH
    } state_t;

    state_t      state;
    logic        din_s1, din_s2, din_d;
    logic        rise, fall;
    logic [11:0] cnt;
    logic [23:0] shreg;
    logic [4:0]  bit_cnt;
    logic [7:0]  pix_cnt;
    logic        got_bit;
    logic        pix_pend;
    logic        latch_evt;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
            din_d  <= 1'b0;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
            din_d  <= din_s2;
        end
    end

    assign rise = din_s2 & ~din_d;
    assign fall = ~din_s2 & din_d;

    // Level-length counter: restarts at 1 on each edge so that at the
    // opposite edge it holds the exact length of the level just ended.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (rise || fall) begin
            cnt <= 12'd1;
        end else if (cnt != '1) begin
            cnt <= cnt + 12'd1;
        end
    end

    // Latch gap seen while waiting for the next bit; fires once per gap
    // because the counter passes T_RESET exactly once.
    assign latch_evt = (state == S_LOW) && (cnt == C_RESET);

    // Receive FSM, bit assembly and registered pixel/frame reporting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_SYNC;
            shreg      <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            got_bit    <= 1'b0;
            pix_pend   <= 1'b0;
            rgb_data   <= '0;
            led_num    <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            pix_pend   <= 1'b0;

            if (pix_pend) begin
                rgb_data <= {shreg[15:8], shreg[23:16], shreg[7:0]};
                led_num  <= pix_cnt;
                valid    <= 1'b1;
                if (pix_cnt != 8'hFF) begin
                    pix_cnt <= pix_cnt + 8'd1;
                end
                if (int'(pix_cnt) >= NUM_LEDS) begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                S_SYNC: begin
                    if (!din_s2 && cnt == C_RESET) begin
                        state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (latch_evt) begin
                        pix_cnt    <= '0;
                        bit_cnt    <= '0;
                        overflow   <= 1'b0;
                        got_bit    <= 1'b0;
                        frame_done <= got_bit;
                        error      <= (bit_cnt != 5'd0);
                    end
                    if (rise) begin
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (cnt > C_MAX) begin
                        error   <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_SYNC;
                    end else if (fall) begin
                        state <= S_LOW;
                        if (cnt >= C_MIN) begin
                            shreg   <= {shreg[22:0], (cnt > C_THRESH)};
                            got_bit <= 1'b1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt  <= '0;
                                pix_pend <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

`ifdef WS2812_RX_FORWARD_EN
    logic fwd_en;

    // Forward the synchronized line once the first pixel of the frame is taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_en <= 1'b0;
            dout   <= 1'b0;
        end else begin
            if (state == S_SYNC || latch_evt) begin
                fwd_en <= 1'b0;
            end else if (pix_pend) begin
                fwd_en <= 1'b1;
            end
            dout <= (fwd_en && state != S_SYNC) ? din_s2 : 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized stimulus for ws2812_rx checked against a
// transaction-level model of the WS2812 receive rules.
`timescale 1ns/1ps
module tb_ws2812_rx;

    localparam int NUM_LEDS = 144;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid, frame_done, error, overflow;
`ifdef WS2812_RX_FORWARD_EN
    logic        dout;
`endif

    ws2812_rx #(
        .NUM_LEDS (NUM_LEDS),
        .CLK_MHZ  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .valid      (valid),
        .frame_done (frame_done),
        .error      (error),
        .overflow   (overflow)
`ifdef WS2812_RX_FORWARD_EN
        ,
        .dout       (dout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic [7:0]  idx;
        logic        ov;
    } pix_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed events
    pix_t        obs_q[$];
    int unsigned obs_fd = 0, obs_err = 0, obs_both = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (valid) obs_q.push_back('{rgb_data, led_num, overflow});
            if (frame_done) obs_fd++;
            if (error) obs_err++;
            if (frame_done && error) obs_both++;
        end
    end

    // Raw line history for checking the forwarded copy
    logic [2:0] din_hist = '0;
    always @(posedge clk) din_hist <= {din_hist[1:0], din};

    // Reference model state
    pix_t        exp_q[$];
    int unsigned exp_fd = 0, exp_err = 0, exp_both = 0;
    bit          m_sync = 1'b1;
    int unsigned m_idx = 0;
    int unsigned m_bitpos = 0;
    bit          m_bits_since = 1'b0;
    int unsigned fwd_mode = 0;

    task automatic fwd_sample();
`ifdef WS2812_RX_FORWARD_EN
        if (fwd_mode == 1) check_eq("dout_idle", 32'(dout), 32'd0);
        else if (fwd_mode == 2) check_eq("dout_follow", 32'(dout), 32'(din_hist[2]));
`endif
    endtask

    task automatic hold(input logic v, input int unsigned n);
        din = v;
        repeat (n) begin
            @(negedge clk);
            fwd_sample();
        end
    endtask

    // mode 0: random legal widths, 1: short widths, 2: nominal 12/8 and 6/14
    task automatic send_bit(input logic b, input int unsigned mode);
        int unsigned hi, lo;
        case (mode)
            0: begin
                hi = b ? $urandom_range(20, 10) : $urandom_range(7, 3);
                lo = $urandom_range(12, 4);
            end
            1: begin
                hi = b ? 10 : 3;
                lo = 3;
            end
            default: begin
                hi = b ? 12 : 6;
                lo = b ? 8 : 14;
            end
        endcase
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    task automatic glitch();
        hold(1'b1, 1);
        hold(1'b0, 5);
    endtask

    task automatic send_pixel(input logic [23:0] grb, input int unsigned mode, input int glitch_after);
        pix_t e;
        for (int unsigned k = 0; k < 24; k++) begin
            send_bit(grb[23 - k], mode);
            if (int'(k) == glitch_after) glitch();
        end
        if (!m_sync) begin
            e.rgb = {grb[15:8], grb[23:16], grb[7:0]};
            e.idx = (m_idx > 255) ? 8'd255 : 8'(m_idx);
            e.ov  = (m_idx >= NUM_LEDS);
            exp_q.push_back(e);
            m_idx++;
            m_bits_since = 1'b1;
        end
    endtask

    task automatic send_partial(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) send_bit(1'($urandom), 0);
        if (!m_sync && n > 0) begin
            m_bitpos = n;
            m_bits_since = 1'b1;
        end
    endtask

    task automatic long_high(input int unsigned n);
        hold(1'b1, n);
        hold(1'b0, 5);
        if (!m_sync) begin
            exp_err++;
            m_sync = 1'b1;
            m_bitpos = 0;
        end
    endtask

    task automatic gap(input int unsigned n);
        hold(1'b0, n);
        if (m_sync) begin
            m_sync = 1'b0;
        end else begin
            if (m_bits_since) exp_fd++;
            if (m_bitpos != 0) exp_err++;
            if (m_bits_since && m_bitpos != 0) exp_both++;
            m_idx = 0;
            m_bitpos = 0;
            m_bits_since = 1'b0;
        end
    endtask

    task automatic compare(input string tag);
        int unsigned n;
        check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            check_eq({tag, "_rgb"}, 32'(obs_q[i].rgb), 32'(exp_q[i].rgb));
            check_eq({tag, "_idx"}, 32'(obs_q[i].idx), 32'(exp_q[i].idx));
            check_eq({tag, "_ovf"}, 32'(obs_q[i].ov), 32'(exp_q[i].ov));
        end
        check_eq({tag, "_frame_done"}, obs_fd, exp_fd);
        check_eq({tag, "_error"}, obs_err, exp_err);
        check_eq({tag, "_both"}, obs_both, exp_both);
        obs_q.delete();
        exp_q.delete();
        obs_fd = 0; obs_err = 0; obs_both = 0;
        exp_fd = 0; exp_err = 0; exp_both = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rgb"}, 32'(rgb_data), 32'd0);
        check_eq({tag, "_led"}, 32'(led_num), 32'd0);
        check_eq({tag, "_valid"}, 32'(valid), 32'd0);
        check_eq({tag, "_fd"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_err"}, 32'(error), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
`ifdef WS2812_RX_FORWARD_EN
        check_eq({tag, "_dout"}, 32'(dout), 32'd0);
`endif
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Bits before the first long low are ignored (SYNC)
        send_pixel(24'hA5A5A5, 0, -1);
        gap(900);
        compare("sync_entry");

        // Nominal pixel
        send_pixel(24'h100000, 2, -1);
        gap(850);
        compare("normal");

        // Directed three-pixel frame, then the next frame restarts at 0
        for (int unsigned p = 0; p < 3; p++) send_pixel(24'($urandom), 0, -1);
        gap(850);
        compare("frame3");
        send_pixel(24'($urandom), 0, -1);
        gap(850);
        compare("restart");

        // Random frames
        for (int unsigned f = 0; f < 3; f++) begin
            int unsigned np = $urandom_range(5, 1);
            for (int unsigned p = 0; p < np; p++) send_pixel(24'($urandom), 0, -1);
            gap(850);
            compare("rand_frame");
        end

        // Overflow: NUM_LEDS+1 pixels
        for (int unsigned p = 0; p < NUM_LEDS + 1; p++) send_pixel(24'($urandom), 1, -1);
        hold(1'b0, 10);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        gap(850);
        compare("overflow");
        check_eq("ovf_clear", 32'(overflow), 32'd0);

        // Glitch between bits is ignored
        send_pixel(24'($urandom), 0, 7);
        gap(850);
        compare("glitch");

        // Over-long high: error, ignored until a full gap
        long_high(40);
        send_pixel(24'($urandom), 0, -1);
        gap(850);
        compare("long_high");
        send_pixel(24'($urandom), 0, -1);
        gap(850);
        compare("after_err");

        // Partial pixel discarded at the latch gap
        send_partial(10);
        gap(850);
        compare("partial");

        // Reset in the middle of a pixel
        send_pixel(24'($urandom), 0, -1);
        send_partial(10);
        hold(1'b1, 4);
        compare("pre_reset");
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        m_sync = 1'b1; m_idx = 0; m_bitpos = 0; m_bits_since = 1'b0;
        hold(1'b0, 5);
        reset_n = 1'b1;
        send_pixel(24'($urandom), 0, -1);
        gap(900);
        send_pixel(24'($urandom), 0, -1);
        gap(850);
        compare("post_reset");

`ifdef WS2812_RX_FORWARD_EN
        // Forwarding: silent during pixel 0, follows the line during pixel 1
        fwd_mode = 1;
        send_pixel(24'($urandom), 2, -1);
        fwd_mode = 2;
        send_pixel(24'($urandom), 2, -1);
        fwd_mode = 0;
        gap(850);
        compare("forward");
        check_eq("dout_after_latch", 32'(dout), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
